// File: rtl/mem_pkg.sv
// mem_pkg: shared data-memory access encodings and arbiter state type.
package mem_pkg;
   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;
   typedef enum logic {ARB_IDLE = 1'b0, ARB_RESP = 1'b1} arb_state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU port, DBG port and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if;
   logic        c_req, d_req, c_we, d_we;
   logic [1:0]  c_store_type, d_store_type;
   logic [2:0]  c_load_type, d_load_type;
   logic [11:0] c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;
   logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
   logic [31:0] c_rdata, d_rdata;
   logic        m_write;
   logic [1:0]  m_store_type;
   logic [2:0]  m_load_type;
   logic [11:0] m_addr;
   logic [31:0] m_wdata, m_rdata;
   modport master (
      output c_req, d_req, c_we, d_we, c_store_type, d_store_type, c_load_type, d_load_type,
             c_addr, d_addr, c_wdata, d_wdata, m_rdata,
      input  c_gnt, d_gnt, c_rvalid, d_rvalid, c_rdata, d_rdata,
             m_write, m_store_type, m_load_type, m_addr, m_wdata
   );
   modport slave (
      input  c_req, d_req, c_we, d_we, c_store_type, d_store_type, c_load_type, d_load_type,
             c_addr, d_addr, c_wdata, d_wdata, m_rdata,
      output c_gnt, d_gnt, c_rvalid, d_rvalid, c_rdata, d_rdata,
             m_write, m_store_type, m_load_type, m_addr, m_wdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority arbiter with burst fairness in front of the
// single-port synchronous-read data memory; holds load address through the response cycle.
module dmem_arbiter
   import mem_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   localparam logic [3:0] MB = 4'(MAX_BURST);
   arb_state_t  state, state_nxt;
   logic        own, idle, c_win, d_win, load_gnt;
   logic [3:0]  burst_cnt;
   logic [11:0] lat_addr;
   logic [2:0]  lat_lt;
   always_comb begin
      idle = rst && state == ARB_IDLE;
      c_win = idle && bus.c_req && (!bus.d_req || burst_cnt != MB);
      d_win = idle && bus.d_req && !c_win;
      load_gnt = (c_win && !bus.c_we) || (d_win && !bus.d_we);
      state_nxt = load_gnt ? ARB_RESP : ARB_IDLE;
      bus.c_gnt = c_win;
      bus.d_gnt = d_win;
      bus.m_write = (c_win && bus.c_we) || (d_win && bus.d_we);
      bus.m_addr = c_win ? bus.c_addr : d_win ? bus.d_addr : lat_addr;
      bus.m_load_type = c_win ? bus.c_load_type : d_win ? bus.d_load_type : lat_lt;
      bus.m_store_type = c_win ? bus.c_store_type : d_win ? bus.d_store_type : ST_SW;
      bus.m_wdata = c_win ? bus.c_wdata : d_win ? bus.d_wdata : 32'h0;
      bus.c_rvalid = rst && state == ARB_RESP && !own;
      bus.d_rvalid = rst && state == ARB_RESP && own;
      bus.c_rdata = bus.c_rvalid ? bus.m_rdata : 32'h0;
      bus.d_rdata = bus.d_rvalid ? bus.m_rdata : 32'h0;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= ARB_IDLE;
      else state <= state_nxt;
   // Latch keeps address and load type stable while the memory returns data.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         own <= 1'b0;
         lat_addr <= '0;
         lat_lt <= LD_LW;
         burst_cnt <= '0;
      end else begin
         if (load_gnt) begin
            own <= d_win;
            lat_addr <= bus.m_addr;
            lat_lt <= bus.m_load_type;
         end
         if (state == ARB_IDLE)
            burst_cnt <= (d_win || !bus.d_req) ? 4'd0 :
                         (c_win && burst_cnt != MB) ? burst_cnt + 4'd1 : burst_cnt;
      end
endmodule
